icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Parameters
REQ-001 The block SHALL take parameter WAYS, default 2, meaning associativity (legal: 1, 2, 4).
REQ-002 The block SHALL take parameter SETS, default 8, meaning number of sets (power of 2, at least 2).
REQ-003 The block SHALL take parameter BLKWORDS, default 2, meaning 32-bit words per block (legal: 1, 2, 4).

Interface
REQ-004 The block SHALL have input CLK, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have input nRST, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have input imemREN, 1 bit, datapath instruction read request.
REQ-007 The block SHALL have input imemaddr, 32 bits, datapath instruction byte address (word aligned).
REQ-008 The block SHALL have output ihit, 1 bit, meaning imemload is valid this cycle.
REQ-009 The block SHALL have output imemload, 32 bits, the instruction word.
REQ-010 The block SHALL have output iREN, 1 bit, memory read request.
REQ-011 The block SHALL have output iaddr, 32 bits, memory word address.
REQ-012 The block SHALL have input iload, 32 bits, memory read data.
REQ-013 The block SHALL have input iwait, 1 bit; 1 means memory busy, 0 means iload is valid this cycle.
REQ-014 The block SHALL have input flush, 1 bit, invalidate-all request.
REQ-015 The block SHALL have output hit_count, 32 bits, saturating hit counter.
REQ-016 The block SHALL have output miss_count, 32 bits, saturating miss counter.

Function
REQ-017 Address fields SHALL be: bits[1:0] byte offset (ignored); next log2(BLKWORDS) bits word offset; next log2(SETS) bits index; remaining upper bits tag.
REQ-018 Per set and way the block SHALL store valid, tag and BLKWORDS data words; per set it SHALL store a round-robin pointer of log2(WAYS) bits (absent when WAYS=1).
REQ-019 FSM states SHALL be IDLE, FILL and FLUSH.
REQ-020 In IDLE, ihit SHALL be combinationally 1 iff imemREN=1 and some way in the indexed set is valid with a matching tag; imemload SHALL then be that way's addressed word, else 32'h0.
REQ-021 In IDLE, imemREN=1 with no hit and flush=0 SHALL latch the block base address (word offset zeroed), clear the word counter, and enter FILL next cycle.
REQ-022 In FILL, iREN SHALL be 1 and iaddr SHALL equal latched base + 4*counter; ihit SHALL be 0.
REQ-023 In FILL, each cycle with iwait=0 SHALL write iload into word[counter] of the victim way and increment the counter.
REQ-024 On the cycle the last word (counter = BLKWORDS-1) is accepted, the victim's tag and valid SHALL be written and the FSM SHALL return to IDLE; a repeat request hits on the next cycle (miss penalty = BLKWORDS accepted words + 1 cycle).
REQ-025 Victim selection SHALL be fixed at FILL entry: the lowest-indexed invalid way, else the way named by the set's round-robin pointer.
REQ-026 When the fill used the round-robin pointer, the pointer SHALL increment modulo WAYS on completion; hits SHALL NOT change it.
REQ-027 Changes of imemaddr or imemREN during FILL SHALL NOT abort or redirect the fill.
REQ-028 In IDLE, flush=1 SHALL take priority over a miss: ihit forced 0, FSM enters FLUSH; FLUSH SHALL clear all valid bits and round-robin pointers in one cycle and return to IDLE.
REQ-029 A flush asserted during FILL SHALL be recorded as pending and applied by entering FLUSH directly after the fill completes.
REQ-030 In IDLE and FLUSH, iREN SHALL be 0 and iaddr SHALL be 32'h0.
REQ-031 hit_count SHALL increment on every cycle with ihit=1; miss_count SHALL increment on every IDLE->FILL transition; both SHALL hold at 32'hFFFFFFFF.

Reset
REQ-032 nRST=0 SHALL asynchronously force: state IDLE, all valid bits 0, all pointers 0, counter 0, pending flush 0, hit_count=0, miss_count=0, iREN=0, iaddr=0, ihit=0.
REQ-033 Reset asserted mid-FILL SHALL abandon the fill with no way left valid; tag and data arrays need not be cleared.

Verification (WAYS=2, SETS=8, BLKWORDS=2)
REQ-034 After reset, read 0x00000100 with iwait=0 -> iREN=1 for 2 cycles, iaddr 0x100 then 0x104; ihit=1 on the following cycle with the 0x100 word; miss_count=1.
REQ-035 Then read 0x00000104 -> ihit=1 in the same cycle with no iREN; hit_count increments by 1.
REQ-036 Fill 0x100, 0x140 and 0x180 (all index 0) -> 0x180 evicts way 0 (0x100); a re-read of 0x100 misses and evicts way 1 (0x140).
REQ-037 Assert flush during a fill with iwait=1 for 3 cycles -> fill completes, one FLUSH cycle follows, and the next read of the filled block misses.
REQ-038 Pull nRST low mid-FILL -> iREN drops immediately, counters read 0, and a re-read of the same address misses.
REQ-039 Preload miss_count to saturation via force -> a further miss leaves it at 32'hFFFFFFFF.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with round-robin replacement,
// blocking multi-word refill, invalidate-all flush and saturating hit/miss counters.
//
// state | meaning
// IDLE  | lookup; hits served combinationally, a miss starts a refill
// FILL  | fetch BLKWORDS words of the missing block into the chosen victim way
// FLUSH | clear every valid bit and round-robin pointer, then back to IDLE
module icache_assoc #(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WOFF = $clog2(BLKWORDS);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - WOFF - IDXW;
    localparam int CNTW = (WOFF > 0) ? WOFF : 1;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t            r_state;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAGW-1:0]   r_tag   [SETS][WAYS];
    logic [31:0]       r_data  [SETS][WAYS][BLKWORDS];
    logic [WAYW-1:0]   r_rr    [SETS];
    logic [CNTW-1:0]   r_cnt;
    logic [IDXW-1:0]   r_idx;
    logic [TAGW-1:0]   r_ftag;
    logic [WAYW-1:0]   r_victim;
    logic              r_use_rr;
    logic              r_pend;
    logic              r_iren;
    logic [31:0]       r_iaddr;
    logic [31:0]       r_hits;
    logic [31:0]       r_misses;

    logic [CNTW-1:0]   w_woff;
    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic              w_match;
    logic [WAYW-1:0]   w_hway;
    logic              w_inv_found;
    logic [WAYW-1:0]   w_inv_way;
    logic [WAYW-1:0]   w_victim;
    logic              w_unused;

    // Byte-offset bits are never looked at; keep them visibly consumed.
    assign w_unused = &{1'b0, imemaddr[1:0]};

    assign w_woff = CNTW'(imemaddr[31:2]) & CNTW'(BLKWORDS - 1);
    assign w_idx  = IDXW'(imemaddr[31:2] >> WOFF);
    assign w_tag  = TAGW'(imemaddr[31:2] >> (WOFF + IDXW));

    // Tag compare across the ways of the indexed set.
    always_comb begin
        w_match = 1'b0;
        w_hway  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_match = 1'b1;
                w_hway  = WAYW'(w);
            end
        end
    end

    // Victim choice: lowest invalid way wins, otherwise the set's round-robin pointer.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAYW'(w);
            end
        end
        w_victim = w_inv_found ? w_inv_way : r_rr[w_idx];
    end

    // A pending flush request masks hits so nothing is served from a cache being invalidated.
    assign ihit     = (r_state == IDLE) && imemREN && !flush && w_match;
    assign imemload = ihit ? r_data[w_idx][w_hway][w_woff] : 32'h0;

    // Control FSM, bookkeeping state and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
            r_cnt    <= '0;
            r_idx    <= '0;
            r_ftag   <= '0;
            r_victim <= '0;
            r_use_rr <= 1'b0;
            r_pend   <= 1'b0;
            r_iren   <= 1'b0;
            r_iaddr  <= 32'h0;
            r_hits   <= 32'h0;
            r_misses <= 32'h0;
        end else begin
            if (ihit && (r_hits != 32'hFFFF_FFFF))
                r_hits <= r_hits + 32'd1;
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (imemREN && !w_match) begin
                        r_state  <= FILL;
                        r_idx    <= w_idx;
                        r_ftag   <= w_tag;
                        r_cnt    <= '0;
                        r_victim <= w_victim;
                        r_use_rr <= !w_inv_found;
                        r_iren   <= 1'b1;
                        r_iaddr  <= imemaddr & ~(32'(4 * BLKWORDS) - 32'd1);
                        if (r_misses != 32'hFFFF_FFFF)
                            r_misses <= r_misses + 32'd1;
                    end
                end
                FILL: begin
                    if (flush)
                        r_pend <= 1'b1;
                    if (!iwait) begin
                        if (r_cnt == CNTW'(BLKWORDS - 1)) begin
                            r_valid[r_idx][r_victim] <= 1'b1;
                            if (r_use_rr && (WAYS > 1))
                                r_rr[r_idx] <= r_rr[r_idx] + 1'b1;
                            r_cnt   <= '0;
                            r_iren  <= 1'b0;
                            r_iaddr <= 32'h0;
                            r_pend  <= 1'b0;
                            r_state <= (r_pend || flush) ? FLUSH : IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_iaddr <= r_iaddr + 32'd4;
                        end
                    end
                end
                FLUSH: begin
                    for (int s = 0; s < SETS; s++) begin
                        r_valid[s] <= '0;
                        r_rr[s]    <= '0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone decides what is usable.
    always_ff @(posedge CLK) begin
        if ((r_state == FILL) && !iwait) begin
            r_data[r_idx][r_victim][r_cnt] <= iload;
            if (r_cnt == CNTW'(BLKWORDS - 1))
                r_tag[r_idx][r_victim] <= r_ftag;
        end
    end

    assign iREN       = r_iren;
    assign iaddr      = r_iaddr;
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: transaction-level cache model (per-set valid/tag/pointer
// arrays, memory as a fixed function of address) driving per-cycle expectations.
module tb_icache_assoc;

    localparam int WAYS = 2;
    localparam int SETS = 8;
    localparam int BW   = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = 32'h0;
    logic        iwait = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BW)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;

    logic        e_en = 1'b0;
    logic        e_ihit;
    logic [31:0] e_load, e_iaddr, e_hits, e_miss;
    logic        e_iren;
    logic        last_hit;

    bit          mv  [SETS][WAYS];
    int unsigned mt  [SETS][WAYS];
    int          mrr [SETS];
    logic [31:0] m_hits = 0;
    logic [31:0] m_miss = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 1) << 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
        end
    endtask

    // Single compare process: every enabled cycle, mid low phase, well clear of the rising edge.
    always @(negedge CLK) begin
        #2;
        if (e_en) begin
            chk("ihit", {31'b0, ihit}, {31'b0, e_ihit});
            chk("imemload", imemload, e_load);
            chk("iREN", {31'b0, iREN}, {31'b0, e_iren});
            chk("iaddr", iaddr, e_iaddr);
            chk("hit_count", hit_count, e_hits);
            chk("miss_count", miss_count, e_miss);
        end
    end

    task automatic step(input logic ren, input logic [31:0] a, input logic fl, input logic wt,
                        input logic [31:0] ld, input logic xh, input logic [31:0] xl,
                        input logic xr, input logic [31:0] xa);
        @(negedge CLK);
        imemREN = ren; imemaddr = a; flush = fl; iwait = wt; iload = ld;
        e_ihit = xh; e_load = xl; e_iren = xr; e_iaddr = xa;
        e_hits = m_hits; e_miss = m_miss; e_en = 1'b1;
        #3;
        last_hit = ihit;
    endtask

    // One read request; nwait < 0 picks 0..2 busy cycles per word at random.
    task automatic access(input logic [31:0] a, input int nwait, input bit fl_fill, output bit was_hit);
        int idx, tg, hw, v, nw;
        bit used_rr;
        logic [31:0] base;
        idx = int'((a / (4 * BW)) % SETS);
        tg  = int'(a / (4 * BW * SETS));
        hw  = -1;
        for (int w = 0; w < WAYS; w++) if (mv[idx][w] && mt[idx][w] == tg) hw = w;
        if (hw >= 0) begin
            step(1'b1, a, 1'b0, 1'($urandom), $urandom, 1'b1, memw(a), 1'b0, 32'h0);
            was_hit = last_hit;
            m_hits = sat_inc(m_hits);
            return;
        end
        step(1'b1, a, 1'b0, 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
        was_hit = last_hit;
        m_miss = sat_inc(m_miss);
        v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!mv[idx][w]) v = w;
        used_rr = (v < 0);
        if (used_rr) v = mrr[idx];
        base = a - (a % (4 * BW));
        for (int k = 0; k < BW; k++) begin
            nw = (nwait < 0) ? int'($urandom_range(0, 2)) : nwait;
            for (int j = 0; j < nw; j++)
                step(1'($urandom), rand_addr(), fl_fill, 1'b1, $urandom,
                     1'b0, 32'h0, 1'b1, base + 4 * k);
            step(1'($urandom), rand_addr(), fl_fill, 1'b0, memw(base + 4 * k),
                 1'b0, 32'h0, 1'b1, base + 4 * k);
        end
        mv[idx][v] = 1;
        mt[idx][v] = tg;
        if (used_rr) mrr[idx] = (mrr[idx] + 1) % WAYS;
        if (fl_fill) begin
            step(1'($urandom), rand_addr(), 1'b0, 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
            model_clear();
        end
    endtask

    task automatic flush_idle();
        step(1'($urandom), rand_addr(), 1'b1, 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'($urandom), rand_addr(), 1'b0, 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
        model_clear();
    endtask

    task automatic idle_cycle();
        step(1'b0, rand_addr(), 1'b0, 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit h;
        model_clear();
        #1;
        chk("rst_ihit", {31'b0, ihit}, 32'h0);
        chk("rst_iREN", {31'b0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_miss", miss_count, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Cold miss with no wait states, then same-block hit.
        access(32'h100, 0, 1'b0, h);
        chk("cold_0x100_hit", {31'b0, h}, 32'h0);
        chk("cold_miss_cnt", miss_count, 32'h1);
        access(32'h104, 0, 1'b0, h);
        chk("hit_0x104", {31'b0, h}, 32'h1);
        idle_cycle();
        chk("hit_cnt_after_0x104", hit_count, 32'h1);

        // Set 0 replacement: 0x180 evicts 0x100, re-read of 0x100 evicts 0x140.
        access(32'h140, 0, 1'b0, h);
        chk("fill_0x140_hit", {31'b0, h}, 32'h0);
        access(32'h180, 1, 1'b0, h);
        chk("fill_0x180_hit", {31'b0, h}, 32'h0);
        access(32'h100, 0, 1'b0, h);
        chk("reread_0x100_hit", {31'b0, h}, 32'h0);
        access(32'h140, 0, 1'b0, h);
        chk("evicted_0x140_hit", {31'b0, h}, 32'h0);
        access(32'h104, 0, 1'b0, h);
        chk("kept_0x104_hit", {31'b0, h}, 32'h1);

        // Flush raised while the fill is stalled.
        access(32'h200, 3, 1'b1, h);
        access(32'h200, 0, 1'b0, h);
        chk("after_fill_flush_hit", {31'b0, h}, 32'h0);

        // Flush in IDLE beats a pending hit.
        flush_idle();
        access(32'h204, 0, 1'b0, h);
        chk("after_idle_flush_hit", {31'b0, h}, 32'h0);

        // Reset in the middle of a fill.
        flush_idle();
        step(1'b1, 32'h300, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        m_miss = sat_inc(m_miss);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300);
        e_en = 1'b0;
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        chk("midfill_rst_iREN", {31'b0, iREN}, 32'h0);
        chk("midfill_rst_iaddr", iaddr, 32'h0);
        chk("midfill_rst_hits", hit_count, 32'h0);
        chk("midfill_rst_miss", miss_count, 32'h0);
        model_clear();
        m_hits = 0;
        m_miss = 0;
        @(negedge CLK);
        nRST = 1'b1;
        access(32'h300, 0, 1'b0, h);
        chk("after_rst_0x300_hit", {31'b0, h}, 32'h0);

        // Miss counter saturation.
        flush_idle();
        force dut.r_misses = 32'hFFFF_FFFF;
        #1;
        release dut.r_misses;
        m_miss = 32'hFFFF_FFFF;
        access(32'h3C0, 0, 1'b0, h);
        idle_cycle();
        chk("miss_saturated", miss_count, 32'hFFFF_FFFF);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: flush_idle();
                1: idle_cycle();
                default: access(rand_addr(), -1, ($urandom_range(0, 7) == 0), h);
            endcase
        end
        idle_cycle();
        e_en = 1'b0;
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
